// File: rtl/au_gray_conv_arb_if.sv
// au_gray_conv_arb_if: request/result bundle for the shared Gray converter
interface au_gray_conv_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_mode;
  modport slave (
    input  req_valid, req_data, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_id, out_mode
  );
  modport master (
    output req_valid, req_data, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_mode
  );
endinterface

// File: rtl/au_gray_conv_arb.sv
// au_gray_conv_arb: round-robin shared binary<->Gray converter with one registered output slot
module au_gray_conv_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst,
  au_gray_conv_arb_if.slave  io
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q, rr_q, rr_d, gnt, idx;
  logic             mode_q, found, can_accept, xfer;
  logic [WIDTH-1:0] words [NREQ];
  function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] w, input logic m);
    logic [WIDTH-1:0] b;
    b = w;
    for (int k = WIDTH - 2; k >= 0; k--) b[k] = b[k+1] ^ w[k];
    return m ? b : w ^ (w >> 1);
  endfunction
  always_comb begin
    for (int k = 0; k < NREQ; k++) words[k] = io.req_data[k*WIDTH +: WIDTH];
  end
  // Walk the ring from rr_q; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && io.req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end
  assign can_accept   = (state_q == EMPTY) || io.out_ready;
  assign xfer         = found && can_accept && !rst;
  assign rr_d         = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
  assign io.req_ready = xfer ? NREQ'(1) << gnt : '0;
  assign io.out_valid = (state_q == FULL);
  assign io.out_data  = data_q;
  assign io.out_id    = id_q;
  assign io.out_mode  = mode_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      mode_q  <= 1'b0;
      rr_q    <= '0;
    end else if (xfer) begin
      state_q <= FULL;
      data_q  <= conv(words[gnt], io.req_mode[gnt]);
      id_q    <= gnt;
      mode_q  <= io.req_mode[gnt];
      rr_q    <= rr_d;
    end else if (io.out_ready) begin
      state_q <= EMPTY;
    end
  end
endmodule

// File: tb/tb_au_gray_conv_arb.sv
// tb_au_gray_conv_arb: directed checks of arbitration order, conversion and back-pressure
module tb_au_gray_conv_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;
  logic [7:0] gv, cur_data;
  au_gray_conv_arb_if #(.WIDTH(8), .NREQ(4)) bus ();
  au_gray_conv_arb #(.WIDTH(8), .NREQ(4)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put(input int i, input logic [7:0] d, input logic m);
    bus.req_data[i*8 +: 8] = d;
    bus.req_mode[i] = m;
  endtask
  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  initial begin
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.req_mode  = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    put(0, 8'h05, 1'b0);
    rst = 1'b0;
    #1;
    chk("first_grant", bus.req_ready, 4'b0001);
    step();
    chk("first_id", bus.out_id, 0);
    chk("first_data", bus.out_data, 8'h07);
    bus.req_valid = 4'b0100;
    put(2, 8'h0B, 1'b0);
    #1;
    chk("single_ready", bus.req_ready, 4'b0100);
    step();
    chk("single_valid", bus.out_valid, 1'b1);
    chk("single_data", bus.out_data, 8'h0E);
    chk("single_id", bus.out_id, 2);
    chk("single_mode", bus.out_mode, 1'b0);
    bus.req_valid = 4'b0010;
    put(1, 8'h0E, 1'b1);
    step();
    chk("g2b_0e_data", bus.out_data, 8'h0B);
    chk("g2b_0e_id", bus.out_id, 1);
    chk("g2b_0e_mode", bus.out_mode, 1'b1);
    bus.req_valid = 4'b1000;
    put(3, 8'h80, 1'b1);
    step();
    chk("g2b_80_data", bus.out_data, 8'hFF);
    chk("g2b_80_id", bus.out_id, 3);
    bus.req_valid = 4'b0001;
    put(0, 8'h00, 1'b1);
    #1;
    chk("wrap_grant", bus.req_ready, 4'b0001);
    step();
    chk("g2b_00_data", bus.out_data, 8'h00);
    bus.req_valid = 4'b0000;
    #1;
    chk("idle_ready", bus.req_ready, 4'b0000);
    step();
    chk("idle_drain", bus.out_valid, 1'b0);
    bus.req_valid = 4'b0001;
    for (int v = 0; v < 256; v++) begin
      gv = b2g(8'(v));
      put(0, 8'(v), 1'b0);
      step();
      chk("rt_b2g", bus.out_data, gv);
      put(0, gv, 1'b1);
      step();
      chk("rt_g2b", bus.out_data, v);
    end
    for (int i = 0; i < 4; i++) put(i, 8'(8'h10 * i + 1), 1'b0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", bus.out_valid, 1'b1);
      chk("rr_id", bus.out_id, (1 + k) % 4);
      chk("rr_data", bus.out_data, b2g(8'(8'h10 * ((1 + k) % 4) + 1)));
    end
    cur_data = b2g(8'h01);
    bus.out_ready = 1'b0;
    #1;
    chk("stall_ready0", bus.req_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_id", bus.out_id, 0);
      chk("stall_data", bus.out_data, cur_data);
      chk("stall_ready", bus.req_ready, 4'b0000);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("resume_ready", bus.req_ready, 4'b0010);
    step();
    chk("resume_valid", bus.out_valid, 1'b1);
    chk("resume_id", bus.out_id, 1);
    chk("resume_data", bus.out_data, b2g(8'h11));
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_ready", bus.req_ready, 4'b0000);
    bus.req_valid = 4'b1010;
    step();
    rst = 1'b0;
    #1;
    chk("postrst_grant", bus.req_ready, 4'b0010);
    step();
    chk("postrst_id", bus.out_id, 1);
    chk("postrst_valid", bus.out_valid, 1'b1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
